// File: rtl/kpyd_scan_if.sv
// Consumer-side handshake for the keypad scanner: accepted key code with
// valid/ready flow control and a one-cycle overrun indication.
interface kpyd_scan_if;
   logic [7:0] kpyd_o;
   logic       valid_o;
   logic       ready_i;
   logic       overrun_o;

   modport master (
      output kpyd_o,
      output valid_o,
      output overrun_o,
      input  ready_i
   );

   modport slave (
      input  kpyd_o,
      input  valid_o,
      input  overrun_o,
      output ready_i
   );
endinterface

// File: rtl/kpyd_scan.sv
// 4x4 keypad matrix scanner. Drives rows one-hot, samples synchronized
// columns at the end of each row dwell, reduces every full scan to a single
// candidate code (or none), debounces press and release over debounce_p
// identical scans and hands accepted codes to the consumer over valid/ready.
module kpyd_scan #(
   parameter int scan_div_p = 1000,
   parameter int debounce_p = 4
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [3:0]  col_i,
   output logic [3:0]  row_o,
   kpyd_scan_if.master bus
);

   localparam int DW = $clog2(scan_div_p);
   localparam int MW = $clog2(debounce_p + 1);

   localparam logic [DW-1:0] DWELL_LAST = DW'(scan_div_p - 1);
   localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
   localparam logic [MW-1:0] MATCH_DONE = MW'(debounce_p);
   localparam logic [MW-1:0] MATCH_ONE  = MW'(1);
   // With a single required scan there is no confirm/release phase at all.
   localparam bit            ONE_SHOT   = (debounce_p == 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONFIRM,
      S_HELD,
      S_RELEASE
   } state_t;

   // ------------------------------------------------------------------
   // Column synchronizer
   // ------------------------------------------------------------------
   logic [3:0] col_s1, col_s2;

   // Two-flop synchronizer: col_i is driven by the keypad, not by clk_i.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         col_s1 <= '0;
         col_s2 <= '0;
      end else begin
         col_s1 <= col_i;
         col_s2 <= col_s1;
      end
   end

   // ------------------------------------------------------------------
   // Row drive and dwell timing
   // ------------------------------------------------------------------
   logic [3:0]    row_q;
   logic [DW-1:0] dwell_q;
   logic          sample_pt;
   logic          scan_done;

   // The last dwell cycle of a row is its sample point; the one for row 3
   // also closes the full scan.
   assign sample_pt = (dwell_q == DWELL_LAST);
   assign scan_done = sample_pt & row_q[3];

   // Dwell counter and rotating one-hot row pointer.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         row_q   <= 4'b0001;
         dwell_q <= '0;
      end else if (sample_pt) begin
         row_q   <= {row_q[2:0], row_q[3]};
         dwell_q <= '0;
      end else begin
         dwell_q <= dwell_q + DWELL_ONE;
      end
   end

   // ------------------------------------------------------------------
   // Per-row column capture and scan reduction
   // ------------------------------------------------------------------
   logic [2:0][3:0] cols_q;

   // Remember the columns seen for rows 0..2; row 3 is used live from the
   // synchronizer because its sample point is the scan boundary itself.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cols_q <= '0;
      end else if (sample_pt) begin
         for (int r = 0; r < 3; r++) begin
            if (row_q[r]) cols_q[r] <= col_s2;
         end
      end
   end

   logic [3:0][3:0] scan_mat;
   logic [2:0]      hit_rows;
   logic            multi_col;
   logic [3:0]      cand_row;
   logic [3:0]      cand_col;
   logic [7:0]      cand_code;
   logic            cand_vld;

   // Reduce the scan matrix: exactly one row with exactly one column gives a
   // candidate, everything else (idle, ghosting, chords) counts as none.
   always_comb begin
      scan_mat  = {col_s2, cols_q};
      hit_rows  = '0;
      multi_col = 1'b0;
      cand_row  = '0;
      cand_col  = '0;
      for (int r = 0; r < 4; r++) begin
         if (|scan_mat[r]) begin
            hit_rows = hit_rows + 3'd1;
            if ($countones(scan_mat[r]) != 1) multi_col = 1'b1;
            cand_row    = '0;
            cand_row[r] = 1'b1;
            cand_col    = scan_mat[r];
         end
      end
      cand_code = {cand_row, cand_col};
      cand_vld  = (hit_rows == 3'd1) && !multi_col;
   end

   // ------------------------------------------------------------------
   // Debounce FSM
   // ------------------------------------------------------------------
   state_t        state_q, state_d;
   logic [MW-1:0] mcnt_q, mcnt_d;
   logic [7:0]    code_q, code_d;
   logic          same_code;
   logic          accept;

   assign same_code = (cand_code == code_q);

   // State register together with the match counter and the code under test.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         mcnt_q  <= '0;
         code_q  <= '0;
      end else begin
         state_q <= state_d;
         mcnt_q  <= mcnt_d;
         code_q  <= code_d;
      end
   end

   // Next-state logic; all transitions happen only on a scan boundary.
   always_comb begin
      state_d = state_q;
      mcnt_d  = mcnt_q;
      code_d  = code_q;
      if (scan_done) begin
         case (state_q)
            S_IDLE: begin
               if (cand_vld) begin
                  if (ONE_SHOT) begin
                     state_d = S_HELD;
                     mcnt_d  = '0;
                  end else begin
                     state_d = S_CONFIRM;
                     mcnt_d  = MATCH_ONE;
                     code_d  = cand_code;
                  end
               end
            end
            S_CONFIRM: begin
               if (!cand_vld) begin
                  state_d = S_IDLE;
                  mcnt_d  = '0;
               end else if (same_code) begin
                  if (mcnt_q + MATCH_ONE == MATCH_DONE) begin
                     state_d = S_HELD;
                     mcnt_d  = '0;
                  end else begin
                     mcnt_d  = mcnt_q + MATCH_ONE;
                  end
               end else begin
                  code_d = cand_code;
                  mcnt_d = MATCH_ONE;
               end
            end
            S_HELD: begin
               if (!cand_vld) begin
                  if (ONE_SHOT) begin
                     state_d = S_IDLE;
                     mcnt_d  = '0;
                  end else begin
                     state_d = S_RELEASE;
                     mcnt_d  = MATCH_ONE;
                  end
               end
            end
            S_RELEASE: begin
               if (cand_vld) begin
                  state_d = S_HELD;
                  mcnt_d  = '0;
               end else if (mcnt_q + MATCH_ONE == MATCH_DONE) begin
                  state_d = S_IDLE;
                  mcnt_d  = '0;
               end else begin
                  mcnt_d  = mcnt_q + MATCH_ONE;
               end
            end
            default: begin
               state_d = S_IDLE;
               mcnt_d  = '0;
            end
         endcase
      end
   end

   // Accept strobe: the scan that completes the debounce_p-th match.
   always_comb begin
      accept = 1'b0;
      if (scan_done && cand_vld) begin
         case (state_q)
            S_IDLE:    accept = ONE_SHOT;
            S_CONFIRM: accept = same_code && (mcnt_q + MATCH_ONE == MATCH_DONE);
            default:   accept = 1'b0;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Output buffer and handshake
   // ------------------------------------------------------------------
   logic [7:0] kpyd_q;
   logic       valid_q;
   logic       ovr_q;
   logic       load;
   logic       drop;

   // A pending code may only be replaced when the consumer takes it in the
   // same cycle; otherwise the new press is dropped and flagged.
   assign load = accept && (!valid_q || bus.ready_i);
   assign drop = accept && valid_q && !bus.ready_i;

   // Output code register, valid flag and overrun pulse.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         kpyd_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         ovr_q <= drop;
         if (load) begin
            kpyd_q  <= cand_code;
            valid_q <= 1'b1;
         end else if (valid_q && bus.ready_i) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign row_o         = row_q;
   assign bus.kpyd_o    = kpyd_q;
   assign bus.valid_o   = valid_q;
   assign bus.overrun_o = ovr_q;

endmodule

// File: tb/tb_kpyd_scan.sv
// Bench for kpyd_scan: directed table of keypad scenarios, reset corner
// sequences and randomized key/ready traffic, all checked every cycle
// against a scan-level reference model of the keypad protocol.
module tb_kpyd_scan;

   localparam int DIV = 4;
   localparam int DEB = 2;
   localparam int SCAN = 4 * DIV;

   logic       clk = 1'b0;
   logic       reset_i;
   logic [3:0] col_i;
   logic [3:0] row_o;

   kpyd_scan_if kif ();

   kpyd_scan #(.scan_div_p(DIV), .debounce_p(DEB)) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .col_i   (col_i),
      .row_o   (row_o),
      .bus     (kif.master)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // keys: bit r*4+c set means the key at row r, column c is held down
   logic [15:0] keys;
   int          cyc_cnt;
   int          ovr_seen;

   // reference model state
   bit         m_held;
   logic [7:0] m_run_code;
   int         m_run;
   int         m_rel;
   bit         m_valid;
   logic [7:0] m_kpyd;
   bit         m_ovr;

   typedef struct {
      logic [15:0] keys;
      int          scans;
      int          rdy_mode;   // 0 low, 1 high, 2 high only in the final boundary cycle
      logic        exp_valid;
      logic [7:0]  exp_kpyd;
      int          exp_ovr;
   } vec_t;

   vec_t tbl[16];

   task automatic check(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [3:0] cols_of(input logic [3:0] row, input logic [15:0] m);
      logic [3:0] c;
      c = '0;
      for (int r = 0; r < 4; r++) if (row[r]) c |= m[r*4 +: 4];
      return c;
   endfunction

   // A full scan yields a code only when exactly one key is down.
   task automatic scan_code(input logic [15:0] m, output logic found, output logic [7:0] code);
      logic [3:0] rr, cc;
      rr = '0;
      cc = '0;
      found = ($countones(m) == 1);
      for (int i = 0; i < 16; i++) begin
         if (m[i]) begin
            rr[i / 4] = 1'b1;
            cc[i % 4] = 1'b1;
         end
      end
      code = found ? {rr, cc} : 8'h00;
   endtask

   task automatic model_reset();
      m_held = 0; m_run = 0; m_rel = 0; m_run_code = '0;
      m_valid = 0; m_kpyd = '0; m_ovr = 0;
      cyc_cnt = 0;
   endtask

   // One clock cycle: drive inputs, advance the model, clock, compare.
   task automatic cyc(input logic rdy);
      logic       acc, found;
      logic [7:0] code, acode;
      acc = 1'b0;
      acode = '0;
      kif.ready_i = rdy;
      col_i = cols_of(row_o, keys);
      if (cyc_cnt % SCAN == SCAN - 1) begin
         scan_code(keys, found, code);
         if (!m_held) begin
            if (found) begin
               if (m_run > 0 && code == m_run_code) m_run++;
               else begin
                  m_run_code = code;
                  m_run = 1;
               end
               if (m_run == DEB) begin
                  acc = 1'b1; acode = code; m_held = 1; m_run = 0; m_rel = 0;
               end
            end else m_run = 0;
         end else begin
            if (!found) begin
               m_rel++;
               if (m_rel == DEB) begin
                  m_held = 0; m_rel = 0; m_run = 0;
               end
            end else m_rel = 0;
         end
      end
      m_ovr = acc && m_valid && !rdy;
      if (acc && (!m_valid || rdy)) begin
         m_valid = 1;
         m_kpyd = acode;
      end else if (m_valid && rdy) m_valid = 0;

      @(posedge clk);
      #1;
      col_i = cols_of(row_o, keys);
      cyc_cnt++;
      @(negedge clk);
      check("row_o", row_o, 4'b0001 << ((cyc_cnt / DIV) % 4));
      check("valid_o", kif.valid_o, m_valid);
      check("kpyd_o", kif.kpyd_o, m_kpyd);
      check("overrun_o", kif.overrun_o, m_ovr);
      if (kif.overrun_o) ovr_seen++;
   endtask

   task automatic run_step(input logic [15:0] m, input int scans, input int mode);
      keys = m;
      for (int s = 0; s < scans; s++)
         for (int c = 0; c < SCAN; c++)
            cyc((mode == 1) || (mode == 2 && s == scans - 1 && c == SCAN - 1));
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_row"}, row_o, 4'b0001);
      check({tag, "_valid"}, kif.valid_o, 0);
      check({tag, "_kpyd"}, kif.kpyd_o, 8'h00);
      check({tag, "_ovr"}, kif.overrun_o, 0);
   endtask

   // Asynchronous reset in the middle of a cycle, then release on a negedge.
   task automatic async_reset(input string tag);
      #2;
      reset_i = 1'b1;
      #1;
      check_reset_values(tag);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_i = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [15:0] m;
      int r, b1, b2;

      reset_i = 1'b1;
      col_i = '0;
      keys = '0;
      kif.ready_i = 1'b0;
      model_reset();
      ovr_seen = 0;

      tbl[0]  = '{16'h0000, 2, 0, 1'b0, 8'h00, 0};  // idle scanning
      tbl[1]  = '{16'h0200, 4, 0, 1'b1, 8'h42, 0};  // row2/col1 held, not consumed
      tbl[2]  = '{16'h0200, 2, 1, 1'b0, 8'h42, 0};  // consumed, no repeat while held
      tbl[3]  = '{16'h0000, 2, 0, 1'b0, 8'h42, 0};  // release debounced
      tbl[4]  = '{16'h0080, 1, 0, 1'b0, 8'h42, 0};  // single-scan bounce
      tbl[5]  = '{16'h0000, 2, 0, 1'b0, 8'h42, 0};
      tbl[6]  = '{16'h0003, 4, 0, 1'b0, 8'h42, 0};  // two columns in row 0
      tbl[7]  = '{16'h0000, 1, 0, 1'b0, 8'h42, 0};
      tbl[8]  = '{16'h0011, 4, 0, 1'b0, 8'h42, 0};  // two rows, column 0
      tbl[9]  = '{16'h0000, 2, 0, 1'b0, 8'h42, 0};
      tbl[10] = '{16'h0001, 3, 0, 1'b1, 8'h11, 0};  // accept row0/col0
      tbl[11] = '{16'h0000, 2, 0, 1'b1, 8'h11, 0};  // release, still pending
      tbl[12] = '{16'h8000, 3, 0, 1'b1, 8'h11, 1};  // second press dropped
      tbl[13] = '{16'h0000, 2, 0, 1'b1, 8'h11, 0};
      tbl[14] = '{16'h8000, 2, 2, 1'b1, 8'h88, 0};  // taken and replaced same cycle
      tbl[15] = '{16'h0000, 2, 1, 1'b0, 8'h88, 0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_values("reset");
      reset_i = 1'b0;

      for (int i = 0; i < 16; i++) begin
         ovr_seen = 0;
         run_step(tbl[i].keys, tbl[i].scans, tbl[i].rdy_mode);
         check($sformatf("tbl%0d_valid", i), kif.valid_o, tbl[i].exp_valid);
         check($sformatf("tbl%0d_kpyd", i), kif.kpyd_o, tbl[i].exp_kpyd);
         check($sformatf("tbl%0d_ovr_pulses", i), ovr_seen, tbl[i].exp_ovr);
      end

      // Reset while a press is being confirmed; the key stays down.
      run_step(16'h0040, 1, 0);
      keys = 16'h0040;
      repeat (5) cyc(1'b0);
      async_reset("rst_confirm");
      run_step(16'h0040, DEB, 0);
      check("reaccept_valid", kif.valid_o, 1);
      check("reaccept_kpyd", kif.kpyd_o, 8'h24);

      // Reset while a code is pending on the handshake.
      repeat (3) cyc(1'b0);
      async_reset("rst_pending");
      run_step(16'h0000, 2, 0);

      // Randomized presses, chords, bounce lengths and consumer behaviour.
      for (int it = 0; it < 48; it++) begin
         r = $urandom_range(0, 99);
         b1 = $urandom_range(0, 15);
         b2 = (b1 + $urandom_range(1, 15)) % 16;
         if (r < 40) m = 16'h0000;
         else if (r < 85) m = 16'h0001 << b1;
         else m = (16'h0001 << b1) | (16'h0001 << b2);
         run_step(m, $urandom_range(1, 4), $urandom_range(0, 2));
      end
      run_step(16'h0000, 3, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
